// File: rtl/seq_stream_tx_if.sv
// Load port and serial output bundle for seq_stream_tx.
// The master side offers words and observes the stream; the slave side is the transmitter.
interface seq_stream_tx_if #(
  parameter int MAX_LEN = 16,
  parameter int LW      = $clog2(MAX_LEN + 1)
);
  logic               load_valid;
  logic               load_ready;
  logic [MAX_LEN-1:0] load_data;
  logic [LW-1:0]      load_len;
  logic               dout;
  logic               dout_valid;

  modport master (
    output load_valid, load_data, load_len,
    input  load_ready, dout, dout_valid
  );

  modport slave (
    input  load_valid, load_data, load_len,
    output load_ready, dout, dout_valid
  );
endinterface

// File: rtl/seq_stream_tx.sv
// Serial bitstream transmitter: accepts a word of up to MAX_LEN bits and shifts it
// out MSB-first, one bit per clock, alongside a golden Mealy model of PATTERN
// (with overlap) whose exp_y / exp_count can be compared against a detector's output.
module seq_stream_tx #(
  parameter int                 MAX_LEN = 16,
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
  parameter int                 LW      = $clog2(MAX_LEN + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  seq_stream_tx_if.slave tx_bus,
  output logic           busy,
  output logic           done,
  output logic           exp_y,
  output logic [7:0]     exp_count
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [MAX_LEN-1:0]   data_q, data_d;
  logic [LW-1:0]        len_q, len_d;
  logic [LW-1:0]        idx_q, idx_d;
  logic [PAT_LEN-2:0]   hist_q, hist_d;
  logic [7:0]           count_q, count_d;

  logic [LW-1:0]        lenClamped;
  logic [LW-1:0]        shiftAmt;
  logic [PAT_LEN-1:0]   window;

  // The word is stored left-aligned so the current bit is always the top bit of data_q.
  assign lenClamped = (tx_bus.load_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : tx_bus.load_len;
  assign shiftAmt   = LW'(MAX_LEN) - lenClamped;
  assign exp_count  = count_q;

  // State, word and golden-model registers; reset discards any word in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      hist_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      hist_q  <= hist_d;
      count_q <= count_d;
    end
  end

  // Next-state, shifting, golden match and output decode; matches need PAT_LEN bits of one word.
  always_comb begin
    state_d           = state_q;
    data_d            = data_q;
    len_d             = len_q;
    idx_d             = idx_q;
    hist_d            = hist_q;
    count_d           = count_q;
    window            = '0;
    tx_bus.load_ready = 1'b0;
    tx_bus.dout       = 1'b0;
    tx_bus.dout_valid = 1'b0;
    busy              = 1'b0;
    done              = 1'b0;
    exp_y             = 1'b0;

    case (state_q)
      IDLE: begin
        tx_bus.load_ready = 1'b1;
        if (tx_bus.load_valid) begin
          data_d  = tx_bus.load_data << shiftAmt;
          len_d   = lenClamped;
          idx_d   = '0;
          hist_d  = '0;
          state_d = (lenClamped == '0) ? DONE : SHIFT;
        end
      end

      SHIFT: begin
        busy              = 1'b1;
        tx_bus.dout_valid = 1'b1;
        tx_bus.dout       = data_q[MAX_LEN-1];
        window            = {hist_q, data_q[MAX_LEN-1]};
        exp_y             = (idx_q >= LW'(PAT_LEN - 1)) && (window == PATTERN);
        hist_d            = window[PAT_LEN-2:0];
        data_d            = data_q << 1;
        idx_d             = idx_q + LW'(1);
        if (exp_y && (count_q != 8'hFF)) begin
          count_d = count_q + 8'd1;
        end
        if (idx_q == len_q - LW'(1)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_stream_tx.sv
// Randomized self-checking bench for seq_stream_tx against a word-level reference model.
module tb_seq_stream_tx;
  localparam int              MAX_LEN = 16;
  localparam int              PAT_LEN = 4;
  localparam int              LW      = 5;
  localparam logic [PAT_LEN-1:0] PATTERN = 4'b1101;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       busy;
  logic       done;
  logic       expY;
  logic [7:0] expCount;

  int checks        = 0;
  int fails         = 0;
  int modelCount    = 0;
  int cycle         = 0;
  int firstBitCycle = 0;
  int gapStart;

  seq_stream_tx_if #(.MAX_LEN(MAX_LEN), .LW(LW)) txBus ();

  seq_stream_tx #(
    .MAX_LEN(MAX_LEN),
    .PAT_LEN(PAT_LEN),
    .PATTERN(PATTERN),
    .LW     (LW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_bus   (txBus.slave),
    .busy     (busy),
    .done     (done),
    .exp_y    (expY),
    .exp_count(expCount)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Cycle counter used to measure spacing between words.
  always @(posedge clk) cycle <= cycle + 1;

  // Guard against a hung run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Counts one comparison and reports it if observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: observed %0h expected %0h at t=%0t", tag, observed, expected, $time);
    end
  endtask

  // Scribbles on the load port while a word is in flight, or holds / drops it.
  task automatic driveBusy(input bit noise, input bit holdValid);
    if (noise) begin
      txBus.load_valid = 1'($urandom_range(0, 1));
      txBus.load_data  = 16'($urandom);
      txBus.load_len   = LW'($urandom);
    end else if (!holdValid) begin
      txBus.load_valid = 1'b0;
    end
  endtask

  // Offers one word from IDLE and checks every cycle of its transmission against the model.
  task automatic applyStimulus(input logic [15:0] data, input int len, input bit noise, input bit holdValid);
    int                 lc;
    bit                 bits[$];
    bit                 y;
    logic [PAT_LEN-1:0] win;
    lc = (len > MAX_LEN) ? MAX_LEN : len;
    for (int k = 0; k < lc; k++) bits.push_back(data[lc-1-k]);

    txBus.load_valid = 1'b1;
    txBus.load_data  = data;
    txBus.load_len   = LW'(len);
    @(negedge clk);
    checkOutput("idle_ready", txBus.load_ready, 1);
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_valid", txBus.dout_valid, 0);
    @(posedge clk);
    #1 driveBusy(noise, holdValid);

    for (int k = 0; k < lc; k++) begin
      @(negedge clk);
      if (k == 0) firstBitCycle = cycle;
      y = 1'b0;
      if (k >= PAT_LEN - 1) begin
        win = '0;
        for (int j = 0; j < PAT_LEN; j++) win = {win[PAT_LEN-2:0], bits[k-PAT_LEN+1+j]};
        y = (win == PATTERN);
      end
      checkOutput("bit_valid", txBus.dout_valid, 1);
      checkOutput("bit_dout", txBus.dout, bits[k]);
      checkOutput("bit_expy", expY, y);
      checkOutput("bit_count", expCount, modelCount);
      checkOutput("bit_ready", txBus.load_ready, 0);
      checkOutput("bit_done", done, 0);
      if (y && modelCount < 255) modelCount++;
      @(posedge clk);
      #1 driveBusy(noise, holdValid);
    end

    @(negedge clk);
    checkOutput("done_pulse", done, 1);
    checkOutput("done_valid", txBus.dout_valid, 0);
    checkOutput("done_dout", txBus.dout, 0);
    checkOutput("done_ready", txBus.load_ready, 0);
    checkOutput("done_busy", busy, 1);
    checkOutput("done_count", expCount, modelCount);
    @(posedge clk);
    #1;
    if (!holdValid) txBus.load_valid = 1'b0;
  endtask

  // Pulses reset and returns one step after a rising edge with the DUT in IDLE.
  task automatic resetDut();
    rst_n = 1'b0;
    modelCount = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n            = 1'b0;
    txBus.load_valid = 1'b0;
    txBus.load_data  = '0;
    txBus.load_len   = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", txBus.dout_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_expy", expY, 0);
    checkOutput("rst_count", expCount, 0);
    checkOutput("rst_ready", txBus.load_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single known word: matches on bits 3, 6 and 10.
    applyStimulus(16'h06DD, 11, 1'b0, 1'b0);
    checkOutput("single_count", expCount, 3);

    // Back-to-back words with load_valid held high.
    resetDut();
    applyStimulus(16'h000D, 4, 1'b0, 1'b1);
    gapStart = firstBitCycle;
    applyStimulus(16'h000D, 4, 1'b0, 1'b1);
    txBus.load_valid = 1'b0;
    checkOutput("b2b_gap", firstBitCycle - gapStart, 6);
    checkOutput("b2b_count", expCount, 2);

    // Length boundaries.
    applyStimulus(16'hFFFF, 0, 1'b0, 1'b0);
    applyStimulus(16'hA5C3, 20, 1'b0, 1'b0);
    applyStimulus(16'h3B6D, 16, 1'b0, 1'b0);
    applyStimulus(16'h0001, 1, 1'b0, 1'b0);

    // Asynchronous reset in the middle of bit 5 of an 11-bit word.
    txBus.load_valid = 1'b1;
    txBus.load_data  = 16'h06DD;
    txBus.load_len   = LW'(11);
    @(posedge clk);
    #1 txBus.load_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("mid_valid", txBus.dout_valid, 1);
    checkOutput("mid_dout", txBus.dout, 0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", txBus.dout_valid, 0);
    checkOutput("arst_dout", txBus.dout, 0);
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_done", done, 0);
    checkOutput("arst_expy", expY, 0);
    checkOutput("arst_count", expCount, 0);
    checkOutput("arst_ready", txBus.load_ready, 1);
    modelCount = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(16'h06DD, 11, 1'b0, 1'b0);

    // Load port toggled during SHIFT and DONE must not disturb the word.
    for (int i = 0; i < 4; i++) applyStimulus(16'($urandom), $urandom_range(0, 20), 1'b1, 1'b0);

    // Saturation of the match counter.
    for (int i = 0; i < 64; i++) applyStimulus(16'hDDDD, 16, 1'b0, 1'b0);
    checkOutput("sat_count", expCount, 255);
    applyStimulus(16'hDDDD, 16, 1'b0, 1'b0);
    checkOutput("sat_hold", expCount, 255);

    // Randomized words.
    for (int i = 0; i < 30; i++) begin
      applyStimulus(16'($urandom), $urandom_range(0, 31), 1'($urandom_range(0, 1)), 1'b0);
    end

    @(negedge clk);
    checkOutput("end_idle", busy, 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/seq_stream_tx.md
# seq_stream_tx

Bitstream transmitter that produces the serial `din` stream consumed by the sequence-detector blocks. It accepts a word of up to `MAX_LEN` bits through a valid/ready load port and shifts it out MSB-first, one bit per clock, with a qualifying `dout_valid`. It also carries a built-in golden Mealy model of the target pattern, so benches and on-chip self-checks can compare a detector's `y` against `exp_y` and `exp_count` cycle by cycle.

## Interface
- `MAX_LEN`, default 16: maximum word length in bits; must be ≥ `PAT_LEN`.
- `PAT_LEN`, default 4: length of the golden pattern.
- `PATTERN`, default 4'b1101: pattern that the golden model detects, with overlap.
- `LW`, default $clog2(`MAX_LEN`+1): width of `load_len`.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `load_valid` in 1: a load word is offered.
- `load_ready` out 1: block accepts a load this cycle.
- `load_data` in `MAX_LEN`: word to send; bits [len-1:0] are used.
- `load_len` in `LW`: number of bits to send. 0 = empty word. Values above `MAX_LEN` are clamped to `MAX_LEN`.
- `dout` out 1: serial data bit.
- `dout_valid` out 1: `dout` carries a stream bit this cycle.
- `busy` out 1: high in SHIFT and DONE.
- `done` out 1: one-cycle pulse after the last bit of a word.
- `exp_y` out 1: golden Mealy output for the current `dout`.
- `exp_count` out 8: total golden matches since reset; saturates at 255.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **IDLE**
  - `load_ready`=1.
  - A handshake (`load_valid` & `load_ready` at a rising edge) captures the data and the clamped length.
  - The same handshake clears the golden history and the bit index.
  - Next state is SHIFT, or DONE if the length is 0.
- **SHIFT**
  - `dout_valid`=1 and `dout` = data[len-1-idx], where idx runs 0..len-1.
  - idx increments each cycle.
  - After the bit with idx = len-1, the next state is DONE.
  - `load_valid` is ignored.
- **DONE**
  - `done`=1, `load_ready`=0, `dout_valid`=0.
  - Next state is IDLE unconditionally.
- `dout` is 0 whenever `dout_valid`=0.
- **Golden model**
  - hist is a `PAT_LEN`-1 bit register of the previously emitted bits of the current word.
  - `exp_y` = `dout_valid` & ({hist,`dout`} == `PATTERN`), computed combinationally from hist and `dout`.
  - Matches must come from `PAT_LEN` consecutive bits of one word, so the first `PAT_LEN`-1 bits of a word cannot produce a match.
  - hist shifts in `dout` on every `dout_valid` cycle.
  - `exp_count` increments on each `exp_y` cycle and holds at 255.
  - `exp_count` is cleared by reset only, never by a load.
- **Reset**
  - When `rst_n` goes low (at any time, including mid-word), the block enters IDLE immediately.
  - `dout`, `dout_valid`, `busy`, `done`, `exp_y`, `exp_count` and hist all read 0.
  - The word in flight is discarded.
  - `load_ready` reads 1 (IDLE), but no capture occurs while `rst_n` is low.

## Timing
- Handshake at edge T gives:
  - bit k (k = 0..len-1) presented during the cycle after edge T+k;
  - `done` high in the cycle after edge T+len;
  - `load_ready` back to 1 in the cycle after edge T+len+1.
- Latency from accept to the first bit is 1 cycle.
- Word period is len+2 cycles; back-to-back loads are therefore separated by 2 non-valid cycles.
- A zero-length word gives `done` in the cycle after accept, with no `dout_valid`.
- `exp_y` is valid in the same cycle as its `dout`. It therefore aligns with a Mealy detector's `y` when that detector is fed `dout` and is also reset before each word.
- `load_data` and `load_len` are sampled only at the handshake edge and may change freely afterwards.

## Test plan
- **Single word:** reset, then load `load_data`=16'h06DD, `load_len`=11.
  - `dout` sequence 1,1,0,1,1,0,1,1,1,0,1 on 11 consecutive `dout_valid` cycles.
  - `exp_y`=1 on bits 3, 6 and 10.
  - `exp_count`=3, and `done` pulses once, the cycle after bit 10.
- **Back-to-back:** hold `load_valid`=1 with 4'b1101 (len 4) twice.
  - Second word's first bit appears exactly len+2 cycles after the first word's first bit.
  - Golden history does not span the 2-cycle gap.
  - `exp_count` ends at 2.
- **Length boundaries:**
  - len=0: `done` the cycle after accept, no `dout_valid`.
  - len=20: clamped to 16 bits, sending `load_data`[15:0] MSB-first.
  - len=1: a single bit, then `done`.
- **Async reset mid-word:** assert `rst_n`=0 asynchronously at bit 5 of a len-11 word.
  - All outputs go to 0 immediately, with no wait for a clock edge, and `exp_count` reads 0.
  - After release, `load_ready`=1 and a new word transmits correctly.
- **Saturation:** send 64 words of 16'hDDDD (len 16, 4 matches each).
  - `exp_count` reaches 255 and holds there.
  - `exp_y` still pulses on every match.
- **Load during SHIFT:** toggle `load_valid` and `load_data` during SHIFT and DONE.
  - No capture occurs.
  - The stream in flight is unchanged.
